// File: rtl/hsm_poca_verifier.sv
// HSM side of the PoCA handshake: unmask the chip response, verify the public-key hash,
// answer with the HSM public key and derive the shared secret with one time-shared mult + SHA.

module serial_multiplier_283 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         reset,
  input  logic [282:0] ax,
  input  logic [282:0] bx,
  output logic [282:0] cx,
  output logic         done
);
  // GF(2^283) reduction by x^283 + x^12 + x^7 + x^5 + 1
  localparam logic [282:0] POLY = 283'h10A1;

  logic [8:0]   idx;
  logic [282:0] acc_next;

  // MSB-first: acc = acc*x mod p, then add ax when the current bx bit is set
  always_comb begin
    acc_next = {cx[281:0], 1'b0} ^ (cx[282] ? POLY : '0);
    if (bx[idx]) acc_next = acc_next ^ ax;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx   <= '0;
      idx  <= 9'd282;
      done <= 1'b0;
    end else if (reset) begin
      cx   <= '0;
      idx  <= 9'd282;
      done <= 1'b0;
    end else if (!done) begin
      cx <= acc_next;
      if (idx == 9'd0) done <= 1'b1;
      else             idx  <= idx - 9'd1;
    end
  end
endmodule

module sha256_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic [511:0] block,
  output logic [255:0] digest,
  output logic         digest_valid
);
  typedef logic [7:0][31:0]  wv_t;   // [0]=a .. [7]=h
  typedef logic [15:0][31:0] win_t;  // [0]=W_t .. [15]=W_t+15

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam wv_t H0 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic wv_t sha_round(input wv_t v, input logic [31:0] k, input logic [31:0] wt);
    logic [31:0] t1, t2;
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
         ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + wt;
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
         ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    return {v[6:4], v[3] + t1, v[2:0], t1 + t2};
  endfunction

  function automatic win_t sched(input win_t w);
    logic [31:0] s0, s1;
    s0 = rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3);
    s1 = rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10);
    return {s1 + w[9] + s0 + w[0], w[15:1]};
  endfunction

  wv_t        v, v1, v2;
  win_t       w, w1, w2, blk_win;
  logic [5:0] rnd;
  logic       running;
  logic [255:0] fin;

  // two rounds per cycle keeps a full block at 32 cycles
  assign v1 = sha_round(v, K[rnd], w[0]);
  assign w1 = sched(w);
  assign v2 = sha_round(v1, K[{rnd[5:1], 1'b1}], w1[0]);
  assign w2 = sched(w1);

  always_comb begin
    blk_win = '0;
    fin     = '0;
    for (int i = 0; i < 16; i++) blk_win[i] = block[511-32*i -: 32];
    for (int i = 0; i < 8; i++)  fin[255-32*i -: 32] = H0[i] + v2[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v            <= '0;
      w            <= '0;
      rnd          <= '0;
      running      <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else if (init) begin
      v            <= H0;
      w            <= blk_win;
      rnd          <= '0;
      running      <= 1'b1;
      digest_valid <= 1'b0;
    end else if (running) begin
      v   <= v2;
      w   <= w2;
      rnd <= rnd + 6'd2;
      if (rnd == 6'd62) begin
        running      <= 1'b0;
        digest_valid <= 1'b1;
        digest       <= fin;
      end
    end
  end
endmodule

module hsm_poca_verifier #(
  parameter int KEY_SIZE       = 128,
  parameter int MULT_SIZE      = 283,
  parameter int HASH_SIZE      = 256,
  parameter int SIGN_SIZE      = 128,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [MULT_SIZE-1:0]           dh_G,
  input  logic [KEY_SIZE-1:0]            hsm_private_key,
  input  logic [SIGN_SIZE-1:0]           expected_signature,
  input  logic [MULT_SIZE+HASH_SIZE-1:0] response,
  input  logic                           response_valid,
  output logic [MULT_SIZE-1:0]           public_key_hsm,
  output logic                           public_key_hsm_valid,
  output logic [HASH_SIZE-1:0]           secret_key_hsm,
  output logic                           secret_key_ready,
  output logic                           auth_fail,
  output logic [1:0]                     fail_code,
  output logic                           busy
);
  localparam int RESP_W = MULT_SIZE + HASH_SIZE;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int BLK_W  = 512;

  typedef enum logic [3:0] {
    IDLE, HASH_PUB, CHECK, GEN_PUB, MRST, GEN_SHARED, HASH_SHARED, DONE, FAIL
  } state_t;

  state_t                state, state_nx;
  logic [RESP_W-1:0]     mask, unmasked;
  logic [MULT_SIZE-1:0]  rx_pub, mult_ax, mult_bx, mult_cx;
  logic [HASH_SIZE-1:0]  rx_hash, sha_digest;
  logic [BLK_W-1:0]      sha_block;
  logic [WD_W-1:0]       wd_cnt;
  logic                  mult_reset, mult_done, sha_init, sha_valid;
  logic                  wd_run, wd_expire, digest_ok;
  logic                  pub_latch, sec_latch, fail_set;
  logic [1:0]            fail_nx;

  // signature repeated across the whole response, truncated at the top
  always_comb
    for (int i = 0; i < RESP_W; i++) mask[i] = expected_signature[i % SIGN_SIZE];

  assign unmasked  = response ^ mask;
  assign mult_bx   = {{(MULT_SIZE-KEY_SIZE){1'b0}}, hsm_private_key};
  assign busy      = !(state inside {IDLE, DONE, FAIL});
  assign wd_run    = state inside {HASH_PUB, GEN_PUB, GEN_SHARED, HASH_SHARED};
  assign wd_expire = wd_run && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  // first cycle of a hash state fires init; a stale digest_valid is masked for two cycles
  assign sha_init  = (state == HASH_PUB || state == HASH_SHARED) && (wd_cnt == '0);
  assign digest_ok = sha_valid && (wd_cnt >= WD_W'(2));
  assign sha_block = {{(BLK_W-MULT_SIZE){1'b0}}, (state == HASH_SHARED) ? mult_cx : rx_pub};

  serial_multiplier_283 u_mult (
    .clk   (clk),
    .rst_n (reset_n),
    .reset (mult_reset),
    .ax    (mult_ax),
    .bx    (mult_bx),
    .cx    (mult_cx),
    .done  (mult_done)
  );

  sha256_core u_sha (
    .clk          (clk),
    .rst_n        (reset_n),
    .init         (sha_init),
    .block        (sha_block),
    .digest       (sha_digest),
    .digest_valid (sha_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    mult_reset = 1'b1;
    mult_ax    = rx_pub;
    pub_latch  = 1'b0;
    sec_latch  = 1'b0;
    fail_set   = 1'b0;
    fail_nx    = 2'b00;
    case (state)
      IDLE: if (response_valid) state_nx = HASH_PUB;
      HASH_PUB: begin
        if (digest_ok)      state_nx = CHECK;
        else if (wd_expire) begin fail_set = 1'b1; fail_nx = 2'b10; state_nx = FAIL; end
      end
      CHECK: begin
        if (sha_digest == rx_hash) state_nx = GEN_PUB;
        else begin fail_set = 1'b1; fail_nx = 2'b01; state_nx = FAIL; end
      end
      GEN_PUB: begin
        mult_reset = 1'b0;
        mult_ax    = dh_G;
        if (mult_done)      begin pub_latch = 1'b1; state_nx = MRST; end
        else if (wd_expire) begin fail_set = 1'b1; fail_nx = 2'b10; state_nx = FAIL; end
      end
      MRST: state_nx = GEN_SHARED;
      GEN_SHARED: begin
        mult_reset = 1'b0;
        if (mult_done)      state_nx = HASH_SHARED;
        else if (wd_expire) begin fail_set = 1'b1; fail_nx = 2'b10; state_nx = FAIL; end
      end
      HASH_SHARED: begin
        mult_reset = 1'b0;  // keeps cx stable while it is hashed
        if (digest_ok)      begin sec_latch = 1'b1; state_nx = DONE; end
        else if (wd_expire) begin fail_set = 1'b1; fail_nx = 2'b10; state_nx = FAIL; end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt  <= '0;
      rx_pub  <= '0;
      rx_hash <= '0;
    end else begin
      wd_cnt <= (state_nx != state || !wd_run) ? '0 : wd_cnt + WD_W'(1);
      if (state == IDLE && response_valid) begin
        rx_pub  <= unmasked[RESP_W-1:HASH_SIZE];
        rx_hash <= unmasked[HASH_SIZE-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      public_key_hsm       <= '0;
      public_key_hsm_valid <= 1'b0;
      secret_key_hsm       <= '0;
      secret_key_ready     <= 1'b0;
      auth_fail            <= 1'b0;
      fail_code            <= 2'b00;
    end else begin
      if (pub_latch) begin
        public_key_hsm       <= mult_cx;
        public_key_hsm_valid <= 1'b1;
      end
      if (sec_latch) begin
        secret_key_hsm   <= sha_digest;
        secret_key_ready <= 1'b1;
      end
      if (fail_set) begin
        auth_fail <= 1'b1;
        fail_code <= fail_nx;
      end
    end
  end
endmodule

// File: tb/tb_hsm_poca_verifier.sv
// Scoreboard bench for hsm_poca_verifier: golden SHA-256 / GF(2^283) models predict each run.
module tb_hsm_poca_verifier;
  localparam int MS = 283, HS = 256, KS = 128, SS = 128;
  localparam logic [MS-1:0] POLY = 283'h10A1;
  // rv edge -> HASH_PUB (34 cycles: init, 32 round cycles, digest seen) -> CHECK -> GEN_PUB
  localparam int GEN_PUB_ENTRY = 35;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [MS-1:0] pub;
    logic [HS-1:0] sec;
    logic [1:0]    code;
    logic          pkv;
    logic          skr;
    logic          af;
  } exp_t;

  logic clk = 1'b0, reset_n = 1'b0, rst_to_n = 1'b0, response_valid = 1'b0;
  logic [MS-1:0]    dh_G = '0;
  logic [KS-1:0]    priv = '0;
  logic [SS-1:0]    sig = '0;
  logic [MS+HS-1:0] response = '0;
  logic [MS-1:0] pk, pk_t;
  logic [HS-1:0] sk, sk_t;
  logic [1:0]    fc, fc_t;
  logic pkv, skr, af, busy, pkv_t, skr_t, af_t, busy_t;
  int n_cmp = 0, n_mis = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hsm_poca_verifier dut (
    .clk(clk), .reset_n(reset_n), .dh_G(dh_G), .hsm_private_key(priv), .expected_signature(sig),
    .response(response), .response_valid(response_valid), .public_key_hsm(pk),
    .public_key_hsm_valid(pkv), .secret_key_hsm(sk), .secret_key_ready(skr), .auth_fail(af),
    .fail_code(fc), .busy(busy));

  // short watchdog: the 283-cycle multiplier never finishes inside 64 cycles
  hsm_poca_verifier #(.TIMEOUT_CYCLES(64)) dut_to (
    .clk(clk), .reset_n(rst_to_n), .dh_G(dh_G), .hsm_private_key(priv), .expected_signature(sig),
    .response(response), .response_valid(response_valid), .public_key_hsm(pk_t),
    .public_key_hsm_valid(pkv_t), .secret_key_hsm(sk_t), .secret_key_ready(skr_t), .auth_fail(af_t),
    .fail_code(fc_t), .busy(busy_t));

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_ref(input logic [511:0] blk);
    logic [31:0] W [64];
    logic [31:0] H [8];
    logic [31:0] s [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    H = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int t = 0; t < 16; t++) W[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      W[t] = (rr(W[t-2], 17) ^ rr(W[t-2], 19) ^ (W[t-2] >> 10)) + W[t-7] +
             (rr(W[t-15], 7) ^ rr(W[t-15], 18) ^ (W[t-15] >> 3)) + W[t-16];
    s = H;
    for (int t = 0; t < 64; t++) begin
      t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + W[t];
      t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
      s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = H[i] + s[i];
    return r;
  endfunction

  // LSB-first shift-and-add over GF(2^283)
  function automatic logic [MS-1:0] gf_mul(input logic [MS-1:0] a, input logic [MS-1:0] b);
    logic [MS-1:0] r, sh;
    r = '0; sh = a;
    for (int i = 0; i < MS; i++) begin
      if (b[i]) r = r ^ sh;
      sh = {sh[MS-2:0], 1'b0} ^ (sh[MS-1] ? POLY : '0);
    end
    return r;
  endfunction

  function automatic logic [MS+HS-1:0] mk(input logic [SS-1:0] s);
    logic [5*SS-1:0] m;
    m = {5{s}};
    return m[MS+HS-1:0];
  endfunction

  function automatic logic [MS-1:0] rnd283();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[32*i +: 32] = $urandom;
    return t[MS-1:0];
  endfunction

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_one(input string nm, input logic [MS+HS-1:0] resp, input exp_t e);
    exp_t x;
    bit seen = 0, fin = 0;
    sb.push_back(e);
    @(negedge clk); response = resp; response_valid = 1'b1;
    @(negedge clk); response_valid = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      if (pkv) seen = 1;
      if (skr || af) fin = 1;
    end
    chk({nm, ".finished"}, 512'(fin), 512'(1));
    x = sb.pop_front();
    chk({nm, ".pub"},  512'(pk),   512'(x.pub));
    chk({nm, ".pkv"},  512'(pkv),  512'(x.pkv));
    chk({nm, ".pkv_ever"}, 512'(seen), 512'(x.pkv));
    chk({nm, ".sec"},  512'(sk),   512'(x.sec));
    chk({nm, ".skr"},  512'(skr),  512'(x.skr));
    chk({nm, ".af"},   512'(af),   512'(x.af));
    chk({nm, ".code"}, 512'(fc),   512'(x.code));
    chk({nm, ".busy"}, 512'(busy), 512'(0));
  endtask

  initial begin
    logic [511:0] abc;
    logic [MS-1:0] P, p_ext;
    logic [MS+HS-1:0] gold;
    exp_t e_ok, e_bad;
    int hit;

    abc = '0; abc[511:480] = 32'h61626380; abc[7:0] = 8'h18;
    chk("model.sha_abc", 512'(sha_ref(abc)),
        512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));

    // 1: random inputs and response_valid while in reset
    dh_G = rnd283(); response = {rnd283(), 256'(rnd283())}; sig = {$urandom, $urandom, $urandom, $urandom};
    priv = {$urandom, $urandom, $urandom, $urandom}; response_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst.pub", 512'(pk), 512'(0)); chk("rst.pkv", 512'(pkv), 512'(0));
    chk("rst.sec", 512'(sk), 512'(0)); chk("rst.skr", 512'(skr), 512'(0));
    chk("rst.af", 512'(af), 512'(0));  chk("rst.code", 512'(fc), 512'(0));
    chk("rst.busy", 512'(busy), 512'(0));
    response_valid = 1'b0; reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.idle_after", 512'(busy), 512'(0));

    // golden stimulus
    priv = 128'h1FED_CBA9_8765_4321_0FED_CBA9_8765_4323;
    sig  = 128'hA5A5_A5A5_A5A5_A5A5_5A5A_5A5A_5A5A_5A5A;
    dh_G = rnd283(); P = rnd283();
    p_ext = {{(MS-KS){1'b0}}, priv};
    gold = {P, sha_ref({229'b0, P})} ^ mk(sig);
    e_ok  = '{pub: gf_mul(dh_G, p_ext), sec: sha_ref({229'b0, gf_mul(P, p_ext)}),
              code: 2'b00, pkv: 1'b1, skr: 1'b1, af: 1'b0};
    e_bad = '{pub: '0, sec: '0, code: 2'b01, pkv: 1'b0, skr: 1'b0, af: 1'b1};

    // 2: golden
    do_reset();
    run_one("gold", gold, e_ok);

    // 3: response bit 0 flipped
    do_reset();
    run_one("resp_bit0", gold ^ 539'(1), e_bad);

    // 4: signature bit 127 flipped
    do_reset();
    sig[127] = ~sig[127];
    run_one("sig_bit127", gold, e_bad);
    sig[127] = ~sig[127];

    // 6: reset in GEN_SHARED, then a clean second run
    do_reset();
    @(negedge clk); response = gold; response_valid = 1'b1;
    @(negedge clk); response_valid = 1'b0;
    repeat (400) @(negedge clk);
    chk("mid.pkv_before", 512'(pkv), 512'(1));
    reset_n = 1'b0; #1;
    chk("mid.pub", 512'(pk), 512'(0)); chk("mid.pkv", 512'(pkv), 512'(0));
    chk("mid.sec", 512'(sk), 512'(0)); chk("mid.busy", 512'(busy), 512'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_one("rerun", gold, e_ok);

    // 5: watchdog with TIMEOUT_CYCLES=64 on the second instance
    @(negedge clk); reset_n = 1'b0; rst_to_n = 1'b1;
    response = gold; response_valid = 1'b1;
    hit = -1;
    for (int k = 0; k < 400 && hit < 0; k++) begin
      @(negedge clk);
      response_valid = 1'b0;
      if (af_t) hit = k;
    end
    chk("to.cycle", 512'(hit), 512'(GEN_PUB_ENTRY + 64));
    chk("to.code", 512'(fc_t), 512'(2));
    chk("to.pkv", 512'(pkv_t), 512'(0));
    chk("to.pub", 512'(pk_t), 512'(0));
    chk("to.skr", 512'(skr_t), 512'(0));
    chk("to.busy", 512'(busy_t), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
